mem_arbiter: RTL and testbench

- Sequences the single byte-wide RAM port and shares it between instruction fetch (IF, 32-bit word reads) and the memory-access stage (MA, byte/half/word loads and stores).
- Sits between the IF/MA pipeline stages and the external RAM.
- Converts multi-byte requests into little-endian byte transactions, sign/zero-extends loads and raises per-requester busy flags for the pipeline stall logic.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_load_ext.sv | 22 ++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM arbiter: FSM states, width codes, byte counts.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdIf,
    StRdMa,
    StWrMa
  } state_e;

  localparam logic [2:0] WidthByte = 3'b001;
  localparam logic [2:0] WidthHalf = 3'b010;
  localparam logic [2:0] WidthWord = 3'b100;
  localparam int unsigned UnsignedBit = 2;

  localparam logic [2:0] NumByte = 3'd1;
  localparam logic [2:0] NumHalf = 3'd2;
  localparam logic [2:0] NumWord = 3'd4;

  // Unlisted codes (000, 011, 111) fall through to a full word.
  function automatic logic [2:0] width_bytes(input logic [2:0] width);
    logic [2:0] n;
    case (width[1:0])
      WidthByte[1:0]: n = NumByte;
      WidthHalf[1:0]: n = NumHalf;
      default:        n = NumWord;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the arbiter; slave is the arbiter, master the rest.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;
  logic              if_busy;

  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [2:0]        ma_width;
  logic [31:0]       ma_wdata;
  logic              ma_done;
  logic [31:0]       ma_rdata;
  logic              ma_busy;

  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;

  modport slave (
    input  if_req, if_addr, if_flush, ma_req, ma_we, ma_addr, ma_width, ma_wdata, mem_din,
    output if_done, if_data, if_busy, ma_done, ma_rdata, ma_busy, mem_a, mem_dout, mem_wr
  );

  modport master (
    output if_req, if_addr, if_flush, ma_req, ma_we, ma_addr, ma_width, ma_wdata, mem_din,
    input  if_done, if_data, if_busy, ma_done, ma_rdata, ma_busy, mem_a, mem_dout, mem_wr
  );

endinterface

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load according to the MA width code.
module mem_load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  width,
  output logic [31:0] result
);

  logic zext;
  assign zext = width[UnsignedBit];

  always_comb begin
    result = data;
    case (width[1:0])
      WidthByte[1:0]: result = {{24{data[7] & ~zext}}, data[7:0]};
      WidthHalf[1:0]: result = {{16{data[15] & ~zext}}, data[15:0]};
      default:        result = data;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the memory-access stage,
// splitting multi-byte requests into little-endian byte transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              ma_done_q, ma_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ma_rdata_q, ma_rdata_d;

  logic [1:0]        last_lane;
  logic [1:0]        cap_lane;
  logic [31:0]       asm_data;
  logic [31:0]       ext_data;

  // The final byte arrives on the completing edge, so it is merged straight from mem_din.
  assign last_lane = 2'(nbytes_q - 3'd1);
  assign cap_lane  = 2'(cnt_q - 3'd2);

  always_comb begin
    asm_data = buf_q;
    asm_data[{last_lane, 3'b000} +: 8] = bus.mem_din;
  end

  mem_load_ext u_load_ext (
    .data   (asm_data),
    .width  (width_q),
    .result (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    width_d    = width_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    ma_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ma_rdata_d = ma_rdata_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (bus.ma_req && !ma_done_q) begin
          nbytes_d = width_bytes(bus.ma_width);
          width_d  = bus.ma_width;
          wdata_d  = bus.ma_wdata;
          mem_a_d  = bus.ma_addr;
          buf_d    = '0;
          cnt_d    = 3'd1;
          if (bus.ma_we) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.ma_wdata[7:0];
            state_d    = StWrMa;
          end else begin
            state_d = StRdMa;
          end
        end else if (bus.if_req && !if_done_q && !bus.if_flush) begin
          nbytes_d = NumWord;
          mem_a_d  = bus.if_addr;
          buf_d    = '0;
          cnt_d    = 3'd1;
          state_d  = StRdIf;
        end
      end

      StRdIf, StRdMa: begin
        if (state_q == StRdIf && bus.if_flush) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < nbytes_q) begin
            mem_a_d = mem_a_q + ADDR_W'(1);
          end
          if (cnt_q >= 3'd2) begin
            buf_d[{cap_lane, 3'b000} +: 8] = bus.mem_din;
          end
          if (cnt_q == nbytes_q + 3'd1) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            if (state_q == StRdIf) begin
              if_done_d = 1'b1;
              if_data_d = asm_data;
            end else begin
              ma_done_d  = 1'b1;
              ma_rdata_d = ext_data;
            end
          end
        end
      end

      StWrMa: begin
        if (cnt_q < nbytes_q) begin
          mem_a_d    = mem_a_q + ADDR_W'(1);
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end else begin
          mem_wr_d  = 1'b0;
          ma_done_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = 3'd0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      width_q    <= 3'd0;
      wdata_q    <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ma_done_q  <= 1'b0;
      if_data_q  <= '0;
      ma_rdata_q <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      width_q    <= width_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ma_done_q  <= ma_done_d;
      if_data_q  <= if_data_d;
      ma_rdata_q <= ma_rdata_d;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.if_done  = if_done_q;
  assign bus.ma_done  = ma_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ma_rdata = ma_rdata_q;
  assign bus.if_busy  = bus.if_req & ~if_done_q;
  assign bus.ma_busy  = bus.ma_req & ~ma_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a byte-array RAM and a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst, rdy, fill, poke_en;
  logic [11:0] poke_a;
  logic [7:0]  poke_d;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  ram [0:4095];
  logic [7:0]  mdl [0:4095];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  function automatic logic [7:0] dflt(input int i);
    logic [31:0] v;
    v = 32'(i * 37 + 11);
    return v[7:0] ^ 8'h5a;
  endfunction

  // 4 KiB RAM mirrored across the address space; frozen together with the arbiter by rdy.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= dflt(i);
    end else if (poke_en) begin
      ram[poke_a] <= poke_d;
    end else if (rdy && bus.mem_wr) begin
      ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end
    if (rdy) bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl[a[11:0]];
  endfunction

  function automatic int nbytes(input logic [2:0] w);
    return (w[1:0] == 2'b01) ? 1 : (w[1:0] == 2'b10) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    poke_en = 1'b1;
    poke_a  = a[11:0];
    poke_d  = b;
    mdl[a[11:0]] = b;
    step;
    poke_en = 1'b0;
  endtask

  task automatic if_xact(input logic [31:0] addr);
    logic [31:0] exp;
    int e;
    bit seen;
    exp = '0;
    for (int k = 0; k < 4; k++) exp |= 32'(mdl_rd(addr + 32'(k))) << (8 * k);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    #1 check("if_busy", bus.if_busy, 1);
    e = -1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step;
      e++;
      if (e < 4) check("if_a", bus.mem_a, addr + 32'(e));
      if (bus.if_done) begin
        seen = 1'b1;
        check("if_lat", e, 5);
        check("if_data", bus.if_data, exp);
        check("if_busy_done", bus.if_busy, 0);
      end
    end
    if (!seen) check("if_done", bus.if_done, 1);
    bus.if_req = 1'b0;
    step;
    check("if_pulse", bus.if_done, 0);
  endtask

  task automatic ma_xact(input logic we, input logic [31:0] addr, input logic [2:0] width,
                         input logic [31:0] wdata, input int stall);
    logic [31:0] exp;
    int n, lat, e, hold;
    bit seen, en;
    n    = nbytes(width);
    lat  = we ? n : n + 1;
    hold = 0;
    exp  = '0;
    for (int k = 0; k < n; k++) exp |= 32'(mdl_rd(addr + 32'(k))) << (8 * k);
    if (n < 4 && !width[2] && exp[8 * n - 1]) exp |= ~((32'd1 << (8 * n)) - 32'd1);
    bus.ma_req   = 1'b1;
    bus.ma_we    = we;
    bus.ma_addr  = addr;
    bus.ma_width = width;
    bus.ma_wdata = wdata;
    #1 check("ma_busy", bus.ma_busy, 1);
    e = -1;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      en = rdy;
      step;
      if (en) begin
        e++;
      end else begin
        check("stall_a", bus.mem_a, addr + 32'(stall));
        check("stall_wr", bus.mem_wr, we);
        check("stall_done", bus.ma_done, 0);
        hold--;
        if (hold == 0) rdy = 1'b1;
      end
      if (en && e < n) begin
        check("ma_a", bus.mem_a, addr + 32'(e));
        check("ma_wr", bus.mem_wr, we);
        if (we) check("ma_dout", bus.mem_dout, wdata[8 * e +: 8]);
      end
      if (bus.ma_done) begin
        seen = 1'b1;
        check("ma_lat", e, lat);
        if (!we) check("ma_rdata", bus.ma_rdata, exp);
        check("ma_busy_done", bus.ma_busy, 0);
      end else if (en && e == stall) begin
        rdy  = 1'b0;
        hold = 3;
      end
    end
    if (!seen) check("ma_done", bus.ma_done, 1);
    if (we) begin
      check("ma_wr_end", bus.mem_wr, 0);
      for (int k = 0; k < n; k++) mdl[12'(addr + 32'(k))] = wdata[8 * k +: 8];
    end
    bus.ma_req = 1'b0;
    step;
    check("ma_pulse", bus.ma_done, 0);
  endtask

  initial begin
    int e;
    bit seen;
    rst = 1'b1; rdy = 1'b1; fill = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.ma_req = 1'b0; bus.ma_we = 1'b0; bus.ma_addr = '0; bus.ma_width = '0; bus.ma_wdata = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = dflt(i);
    step;
    fill = 1'b0;
    step;
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_mem_dout", bus.mem_dout, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_if_done", bus.if_done, 0);
    check("rst_ma_done", bus.ma_done, 0);
    check("rst_if_data", bus.if_data, 0);
    check("rst_ma_rdata", bus.ma_rdata, 0);
    rst = 1'b0;
    step;

    poke(32'h1000, 8'h13); poke(32'h1001, 8'h00); poke(32'h1002, 8'h00); poke(32'h1003, 8'h93);
    if_xact(32'h1000);
    check("if_word", bus.if_data, 32'h9300_0013);

    // Simultaneous requests: MA byte load wins, IF follows once MA's done has cleared.
    poke(32'h20, 8'h80);
    bus.ma_req = 1'b1; bus.ma_we = 1'b0; bus.ma_addr = 32'h20; bus.ma_width = WidthByte;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    e = -1;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      step;
      e++;
      if (e == 0) check("both_ma_first", bus.mem_a, 32'h20);
      if (e == 3) check("both_if_acc", bus.mem_a, 32'h1000);
      if (bus.ma_done) begin
        check("both_ma_lat", e, 2);
        check("both_ma_rdata", bus.ma_rdata, 32'hffff_ff80);
        bus.ma_req = 1'b0;
      end
      if (bus.if_done) begin
        seen = 1'b1;
        check("both_if_lat", e, 8);
        check("both_if_data", bus.if_data, 32'h9300_0013);
      end
    end
    if (!seen) check("both_if_done", bus.if_done, 1);
    bus.if_req = 1'b0;
    step;

    ma_xact(1'b1, 32'h100, WidthHalf, 32'hdead_beef, -1);
    poke(32'h200, 8'h34); poke(32'h201, 8'hf2);
    ma_xact(1'b0, 32'h200, 3'b110, '0, -1);
    check("half_u", bus.ma_rdata, 32'h0000_f234);
    ma_xact(1'b0, 32'h200, WidthHalf, '0, -1);
    check("half_s", bus.ma_rdata, 32'hffff_f234);
    ma_xact(1'b0, 32'h100, 3'b101, '0, -1);
    check("byte_u", bus.ma_rdata, 32'h0000_00ef);

    // Flush in the third RD_IF cycle, then a fresh fetch the edge after.
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    step; step; step;
    bus.if_flush = 1'b1; bus.if_addr = 32'h1100;
    step;
    check("flush_no_done", bus.if_done, 0);
    bus.if_flush = 1'b0;
    if_xact(32'h1100);
    bus.if_req = 1'b1; bus.if_addr = 32'h1200; bus.if_flush = 1'b1;
    step;
    check("flush_idle_hold", bus.mem_a, 32'h1103);
    bus.if_flush = 1'b0;
    if_xact(32'h1200);
    bus.if_flush = 1'b1;
    ma_xact(1'b0, 32'h1000, WidthWord, '0, -1);
    bus.if_flush = 1'b0;

    ma_xact(1'b1, 32'h300, WidthWord, 32'h0102_0304, 1);
    ma_xact(1'b0, 32'h300, WidthWord, '0, -1);
    check("stall_rdback", bus.ma_rdata, 32'h0102_0304);

    // Reset in the middle of a word store.
    bus.ma_req = 1'b1; bus.ma_we = 1'b1; bus.ma_addr = 32'h500;
    bus.ma_width = WidthWord; bus.ma_wdata = 32'h1122_3344;
    step; step;
    check("rst_wr_pre", bus.mem_wr, 1);
    rst = 1'b1;
    step;
    check("rst_mid_wr", bus.mem_wr, 0);
    check("rst_mid_a", bus.mem_a, 0);
    check("rst_mid_dout", bus.mem_dout, 0);
    check("rst_mid_rdata", bus.ma_rdata, 0);
    mdl[12'h500] = 8'h44;
    mdl[12'h501] = 8'h33;
    rst = 1'b0;
    bus.ma_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      check("rst_no_ma_done", bus.ma_done, 0);
      check("rst_idle_wr", bus.mem_wr, 0);
    end
    ma_xact(1'b0, 32'h500, WidthWord, '0, -1);
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    step; step; step;
    rst = 1'b1;
    step;
    check("rst_if_data_clr", bus.if_data, 0);
    check("rst_if_a", bus.mem_a, 0);
    rst = 1'b0;
    bus.if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      check("rst_no_if_done", bus.if_done, 0);
    end
    if_xact(32'h600);

    if_xact(32'hffff_fffe);
    ma_xact(1'b1, 32'hffff_ffff, WidthHalf, 32'h0000_a55a, -1);
    ma_xact(1'b0, 32'hffff_ffff, 3'b111, '0, -1);

    for (int i = 0; i < 60; i++) begin
      int kind, n, stall;
      logic [31:0] a;
      logic [2:0] w;
      kind = int'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'hffff_fffc + 32'($urandom_range(0, 3));
      w = 3'($urandom_range(0, 7));
      n = nbytes(w);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      if (kind == 0) if_xact(a);
      else ma_xact(kind == 2, a, w, $urandom, stall);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
